// File: rtl/ahb3lite_apb_bridge.sv
// rtl/ahb3lite_apb_bridge.sv - AHB3-Lite to APB bridge; define AHB_APB_SLVERR_EN to forward PSLVERR as an AHB ERROR response
`timescale 1ns/1ps
module ahb3lite_apb_bridge #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32,
  parameter int PADDR_SIZE = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [HADDR_SIZE-1:0]   HADDR,
  input  logic [HDATA_SIZE-1:0]   HWDATA,
  output logic [HDATA_SIZE-1:0]   HRDATA,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HREADY,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic [2:0]              PPROT,
  output logic                    PWRITE,
  output logic [HDATA_SIZE/8-1:0] PSTRB,
  output logic [PADDR_SIZE-1:0]   PADDR,
  output logic [HDATA_SIZE-1:0]   PWDATA,
  input  logic [HDATA_SIZE-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_W = HDATA_SIZE / 8;

  typedef enum logic [2:0] {
    ST_IDLE, ST_WDATA, ST_SETUP, ST_ACCESS, ST_DONE, ST_ERR1, ST_ERR2
  } state_t;

  state_t state;
  logic   accept;
  logic   unused_inputs;

  // HTRANS[0] only separates NONSEQ from SEQ and BUSY from IDLE; HPROT[3:2] has no APB equivalent
  assign unused_inputs = ^{HTRANS[0], HPROT[3:2], PSLVERR};

  // HREADYOUT is high exactly in IDLE, DONE and ERR2, the only states that may take a new address phase
  assign accept = HSEL & HREADY & HTRANS[1] & HREADYOUT;

  // Byte-lane strobes: 2^size lanes from the address offset, saturating to all lanes
  function automatic logic [STRB_W-1:0] gen_strb(input logic [2:0] size,
                                                 input logic [HADDR_SIZE-1:0] addr);
    int bytes;
    int off;
    bytes = 1 << size;
    off   = int'(addr) & (STRB_W - 1);
    if (bytes >= STRB_W) gen_strb = '1;
    else                 gen_strb = STRB_W'((1 << bytes) - 1) << off;
  endfunction

  // Bridge FSM; every bus-facing output is a register updated on the state transition
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PSTRB     <= '0;
      PPROT     <= '0;
      PADDR     <= '0;
      PWDATA    <= '0;
      HRDATA    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERR2: begin
          HRESP   <= 1'b0;
          PSEL    <= 1'b0;
          PENABLE <= 1'b0;
          if (accept) begin
            PADDR     <= HADDR[PADDR_SIZE-1:0];
            PWRITE    <= HWRITE;
            PPROT     <= {~HPROT[0], 1'b1, HPROT[1]};
            PSTRB     <= HWRITE ? gen_strb(HSIZE, HADDR) : '0;
            HREADYOUT <= 1'b0;
            if (HWRITE) begin
              // write data only arrives in the following data phase
              state <= ST_WDATA;
            end else begin
              state <= ST_SETUP;
              PSEL  <= 1'b1;
            end
          end else begin
            HREADYOUT <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        ST_WDATA: begin
          PWDATA <= HWDATA;
          PSEL   <= 1'b1;
          state  <= ST_SETUP;
        end
        ST_SETUP: begin
          PENABLE <= 1'b1;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            if (!PWRITE) HRDATA <= PRDATA;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
`ifdef AHB_APB_SLVERR_EN
            if (PSLVERR) begin
              // two-cycle AHB ERROR: HREADYOUT low in the first cycle, high in the second
              HRESP <= 1'b1;
              state <= ST_ERR1;
            end else begin
              HREADYOUT <= 1'b1;
              state     <= ST_DONE;
            end
`else
            HREADYOUT <= 1'b1;
            state     <= ST_DONE;
`endif
          end
        end
        ST_ERR1: begin
          HREADYOUT <= 1'b1;
          state     <= ST_ERR2;
        end
        default: begin
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          PSEL      <= 1'b0;
          PENABLE   <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
